// File: rtl/cu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cu_pipe_ctrl
// Purpose  : Multi-cycle control unit for a small accumulator datapath.
//            Decodes the current opcode and sequences ALU, load/store
//            (with memory wait states), jump and halt operations. Every
//            control output is a register loaded on the edge that enters
//            the corresponding state.
// Config   : define CU_JMPZ_EN to enable opcode 8 as JMPZ (jump on ZERO);
//            when undefined, opcode 8 is illegal and ZERO is not used.
// Revision : 1.0 - initial release
// ============================================================================
module cu_pipe_ctrl #(
    parameter int OPW      = 4,
    parameter int WAIT_CYC = 2,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] INSTR,
    input  logic           OVF,
    input  logic           ZERO,
    input  logic           mem_ready,
    input  logic           resume,
    output logic           WEa,
    output logic           WEb,
    output logic           WEpc,
    output logic           CTRLa,
    output logic           CTRLpc,
    output logic           CTRLaddr,
    output logic           RW,
    output logic           CIN,
    output logic           busy,
    output logic           halted,
    output logic           illegal
);

    // State encoding
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_MEMRD = 3'd1;
    localparam logic [2:0] c_STRW  = 3'd2;
    localparam logic [2:0] c_JMPS  = 3'd3;
    localparam logic [2:0] c_HALTS = 3'd4;

    // Opcodes (upper bits of INSTR are zero-extended, so any larger value
    // falls through to the illegal/default decode)
    localparam logic [OPW-1:0] c_OP_ADD    = OPW'(0);
    localparam logic [OPW-1:0] c_OP_SBTR   = OPW'(1);
    localparam logic [OPW-1:0] c_OP_LDA    = OPW'(2);
    localparam logic [OPW-1:0] c_OP_LDB    = OPW'(3);
    localparam logic [OPW-1:0] c_OP_STR    = OPW'(4);
    localparam logic [OPW-1:0] c_OP_JMP    = OPW'(5);
    localparam logic [OPW-1:0] c_OP_JMPOVF = OPW'(6);
    localparam logic [OPW-1:0] c_OP_HALT   = OPW'(7);
`ifdef CU_JMPZ_EN
    localparam logic [OPW-1:0] c_OP_JMPZ   = OPW'(8);
`endif
    localparam logic [OPW-1:0] c_OP_NOP    = OPW'(9);

    // Jump condition remembered from decode; the flag itself is sampled in JMPS
    localparam logic [1:0] c_JK_ALWAYS = 2'd0;
    localparam logic [1:0] c_JK_OVF    = 2'd1;
`ifdef CU_JMPZ_EN
    localparam logic [1:0] c_JK_ZERO   = 2'd2;
`endif

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

`ifndef CU_JMPZ_EN
    // ZERO only matters when JMPZ is built in
    logic w_unused_zero;
    assign w_unused_zero = ZERO;
`endif

    logic [2:0]       r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_ld_b, w_ld_b;
    logic [1:0]       r_jkind, w_jkind;
    logic             r_wea, w_wea;
    logic             r_web, w_web;
    logic             r_wepc, w_wepc;
    logic             r_ctrla, w_ctrla;
    logic             r_ctrlpc, w_ctrlpc;
    logic             r_ctrladdr, w_ctrladdr;
    logic             r_rw, w_rw;
    logic             r_cin, w_cin;
    logic             r_busy, w_busy;
    logic             r_halted, w_halted;
    logic             r_illegal, w_illegal;

    assign WEa      = r_wea;
    assign WEb      = r_web;
    assign WEpc     = r_wepc;
    assign CTRLa    = r_ctrla;
    assign CTRLpc   = r_ctrlpc;
    assign CTRLaddr = r_ctrladdr;
    assign RW       = r_rw;
    assign CIN      = r_cin;
    assign busy     = r_busy;
    assign halted   = r_halted;
    assign illegal  = r_illegal;

    // Next-state and next-output decode; outputs default to 0 each cycle
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_ld_b     = r_ld_b;
        w_jkind    = r_jkind;
        w_illegal  = r_illegal;
        w_wea      = 1'b0;
        w_web      = 1'b0;
        w_wepc     = 1'b0;
        w_ctrla    = 1'b0;
        w_ctrlpc   = 1'b0;
        w_ctrladdr = 1'b0;
        w_rw       = 1'b0;
        w_cin      = 1'b0;
        w_busy     = 1'b0;
        w_halted   = 1'b0;

        case (r_state)
            c_IDLE: begin
                case (INSTR)
                    c_OP_ADD: begin
                        w_wea  = 1'b1;
                        w_wepc = 1'b1;
                    end
                    c_OP_SBTR: begin
                        w_wea  = 1'b1;
                        w_wepc = 1'b1;
                        w_cin  = 1'b1;
                    end
                    c_OP_LDA, c_OP_LDB: begin
                        w_cnt   = c_CNT_LOAD;
                        w_ld_b  = (INSTR == c_OP_LDB);
                        w_busy  = 1'b1;
                        w_state = c_MEMRD;
                    end
                    c_OP_STR: begin
                        w_cnt      = c_CNT_LOAD;
                        w_ctrladdr = 1'b1;
                        w_rw       = 1'b1;
                        w_busy     = 1'b1;
                        w_state    = c_STRW;
                    end
                    c_OP_JMP: begin
                        w_jkind = c_JK_ALWAYS;
                        w_state = c_JMPS;
                    end
                    c_OP_JMPOVF: begin
                        w_jkind = c_JK_OVF;
                        w_state = c_JMPS;
                    end
`ifdef CU_JMPZ_EN
                    c_OP_JMPZ: begin
                        w_jkind = c_JK_ZERO;
                        w_state = c_JMPS;
                    end
`endif
                    c_OP_HALT: begin
                        w_halted = 1'b1;
                        w_state  = c_HALTS;
                    end
                    c_OP_NOP: begin
                        w_wepc = 1'b1;
                    end
                    default: begin
                        // Unknown opcode executes as NOP but is flagged until reset
                        w_wepc    = 1'b1;
                        w_illegal = 1'b1;
                    end
                endcase
            end

            c_MEMRD: begin
                if (r_cnt != '0) begin
                    w_cnt  = r_cnt - c_CNT_ONE;
                    w_busy = 1'b1;
                end else if (mem_ready) begin
                    w_wepc  = 1'b1;
                    w_web   = r_ld_b;
                    w_wea   = ~r_ld_b;
                    w_ctrla = ~r_ld_b;
                    w_state = c_IDLE;
                end else begin
                    w_busy = 1'b1;
                end
            end

            c_STRW: begin
                if ((r_cnt == '0) && mem_ready) begin
                    w_wepc  = 1'b1;
                    w_state = c_IDLE;
                end else begin
                    if (r_cnt != '0) begin
                        w_cnt = r_cnt - c_CNT_ONE;
                    end
                    w_rw       = 1'b1;
                    w_ctrladdr = 1'b1;
                    w_busy     = 1'b1;
                end
            end

            c_JMPS: begin
                w_wepc  = 1'b1;
                w_state = c_IDLE;
                case (r_jkind)
                    c_JK_ALWAYS: w_ctrlpc = 1'b1;
                    c_JK_OVF:    w_ctrlpc = OVF;
`ifdef CU_JMPZ_EN
                    c_JK_ZERO:   w_ctrlpc = ZERO;
`endif
                    default:     w_ctrlpc = 1'b0;
                endcase
            end

            c_HALTS: begin
                if (resume) begin
                    w_wepc  = 1'b1;
                    w_state = c_IDLE;
                end else begin
                    w_halted = 1'b1;
                end
            end

            default: begin
                w_wepc  = 1'b1;
                w_state = c_IDLE;
            end
        endcase
    end

    // State and output registers; reset acts immediately so RW drops mid-store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_ld_b     <= 1'b0;
            r_jkind    <= c_JK_ALWAYS;
            r_wea      <= 1'b0;
            r_web      <= 1'b0;
            r_wepc     <= 1'b1;
            r_ctrla    <= 1'b1;
            r_ctrlpc   <= 1'b0;
            r_ctrladdr <= 1'b0;
            r_rw       <= 1'b0;
            r_cin      <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_ld_b     <= w_ld_b;
            r_jkind    <= w_jkind;
            r_wea      <= w_wea;
            r_web      <= w_web;
            r_wepc     <= w_wepc;
            r_ctrla    <= w_ctrla;
            r_ctrlpc   <= w_ctrlpc;
            r_ctrladdr <= w_ctrladdr;
            r_rw       <= w_rw;
            r_cin      <= w_cin;
            r_busy     <= w_busy;
            r_halted   <= w_halted;
            r_illegal  <= w_illegal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_pipe_ctrl
// Purpose  : Directed self-checking bench for cu_pipe_ctrl (default
//            parameters). Output vector bit order, MSB first:
//            WEa WEb WEpc CTRLa CTRLpc CTRLaddr RW CIN busy halted illegal
// Revision : 1.0 - initial release
// ============================================================================
module tb_cu_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] INSTR;
    logic       OVF;
    logic       ZERO;
    logic       mem_ready;
    logic       resume;
    logic       WEa, WEb, WEpc, CTRLa, CTRLpc, CTRLaddr, RW, CIN, busy, halted, illegal;
    logic [10:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    cu_pipe_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .INSTR     (INSTR),
        .OVF       (OVF),
        .ZERO      (ZERO),
        .mem_ready (mem_ready),
        .resume    (resume),
        .WEa       (WEa),
        .WEb       (WEb),
        .WEpc      (WEpc),
        .CTRLa     (CTRLa),
        .CTRLpc    (CTRLpc),
        .CTRLaddr  (CTRLaddr),
        .RW        (RW),
        .CIN       (CIN),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    assign outs = {WEa, WEb, WEpc, CTRLa, CTRLpc, CTRLaddr, RW, CIN, busy, halted, illegal};

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output vectors
    localparam logic [10:0] c_RST   = 11'b0_0_1_1_0_0_0_0_0_0_0;
    localparam logic [10:0] c_ADD   = 11'b1_0_1_0_0_0_0_0_0_0_0;
    localparam logic [10:0] c_SUB   = 11'b1_0_1_0_0_0_0_1_0_0_0;
    localparam logic [10:0] c_WAIT  = 11'b0_0_0_0_0_0_0_0_1_0_0;
    localparam logic [10:0] c_LDA   = 11'b1_0_1_1_0_0_0_0_0_0_0;
    localparam logic [10:0] c_LDB   = 11'b0_1_1_0_0_0_0_0_0_0_0;
    localparam logic [10:0] c_NOP   = 11'b0_0_1_0_0_0_0_0_0_0_0;
    localparam logic [10:0] c_STR   = 11'b0_0_0_0_0_1_1_0_1_0_0;
    localparam logic [10:0] c_ZERO  = 11'b0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] c_JTAK  = 11'b0_0_1_0_1_0_0_0_0_0_0;
    localparam logic [10:0] c_HALT  = 11'b0_0_0_0_0_0_0_0_0_1_0;
    localparam logic [10:0] c_ILLN  = 11'b0_0_1_0_0_0_0_0_0_0_1;
    localparam logic [10:0] c_ILLA  = 11'b1_0_1_0_0_0_0_0_0_0_1;
    localparam logic [10:0] c_STRI  = 11'b0_0_0_0_0_1_1_0_1_0_1;

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        INSTR     = 4'd9;
        OVF       = 1'b0;
        ZERO      = 1'b0;
        mem_ready = 1'b0;
        resume    = 1'b0;

        #7;
        check("reset", outs, c_RST);
        #5;
        reset = 1'b0;

        // ADD, SBTR, ADD back-to-back; a stray resume must be ignored
        resume = 1'b1;
        INSTR = 4'd0; tick; check("add1", outs, c_ADD);
        INSTR = 4'd1; tick; check("sbtr", outs, c_SUB);
        INSTR = 4'd0; tick; check("add2", outs, c_ADD);
        resume = 1'b0;

        // LDA with two wait states, mem_ready from the third cycle
        INSTR = 4'd2; mem_ready = 1'b0; tick; check("lda_e0", outs, c_WAIT);
        INSTR = 4'd9;
        tick; check("lda_e1", outs, c_WAIT);
        tick; check("lda_e2", outs, c_WAIT);
        mem_ready = 1'b1;
        tick; check("lda_done", outs, c_LDA);
        mem_ready = 1'b0;
        tick; check("lda_after", outs, c_NOP);

        // LDB with mem_ready high throughout: wait states still counted
        INSTR = 4'd3; mem_ready = 1'b1; tick; check("ldb_e0", outs, c_WAIT);
        INSTR = 4'd9;
        tick; check("ldb_e1", outs, c_WAIT);
        tick; check("ldb_e2", outs, c_WAIT);
        tick; check("ldb_done", outs, c_LDB);
        mem_ready = 1'b0;

        // STR with mem_ready low for five cycles
        INSTR = 4'd4; tick; check("str_e0", outs, c_STR);
        INSTR = 4'd9;
        for (int k = 1; k <= 5; k++) begin
            tick; check($sformatf("str_hold%0d", k), outs, c_STR);
        end
        mem_ready = 1'b1;
        tick; check("str_done", outs, c_NOP);
        mem_ready = 1'b0;

        // JMPOVF: flag sampled in JMPS, not at decode
        INSTR = 4'd6; OVF = 1'b1; tick; check("jovf0_e0", outs, c_ZERO);
        INSTR = 4'd9; OVF = 1'b0; tick; check("jovf0_e1", outs, c_NOP);
        INSTR = 4'd6; OVF = 1'b0; tick; check("jovf1_e0", outs, c_ZERO);
        INSTR = 4'd9; OVF = 1'b1; tick; check("jovf1_e1", outs, c_JTAK);
        OVF = 1'b0;

        // Unconditional JMP
        INSTR = 4'd5; tick; check("jmp_e0", outs, c_ZERO);
        INSTR = 4'd9; tick; check("jmp_e1", outs, c_JTAK);

`ifdef CU_JMPZ_EN
        INSTR = 4'd8; tick; check("jmpz_e0", outs, c_ZERO);
        INSTR = 4'd9; ZERO = 1'b1; tick; check("jmpz_e1", outs, c_JTAK);
        ZERO = 1'b0;
`endif

        // HALT for ten cycles, then resume; mem_ready in HALTS is ignored
        INSTR = 4'd7; mem_ready = 1'b1; tick; check("halt_e0", outs, c_HALT);
        INSTR = 4'd9;
        for (int k = 1; k <= 9; k++) begin
            tick; check($sformatf("halt_hold%0d", k), outs, c_HALT);
        end
        mem_ready = 1'b0;
        resume = 1'b1;
        tick; check("halt_resume", outs, c_NOP);
        resume = 1'b0;
        INSTR = 4'd0; tick; check("halt_idle_add", outs, c_ADD);

`ifndef CU_JMPZ_EN
        INSTR = 4'd8; tick; check("op8_illegal", outs, c_ILLN);
`endif
        // Opcode 12 is illegal and the flag is sticky
        INSTR = 4'd12; tick; check("op12_illegal", outs, c_ILLN);
        INSTR = 4'd0;  tick; check("illegal_sticky", outs, c_ILLA);

        // Reset mid-store drops RW without a clock edge
        INSTR = 4'd4; tick; check("str2_e0", outs, c_STRI);
        INSTR = 4'd9;
        #2 reset = 1'b1;
        #1;
        check("rst_async_rw", {10'd0, RW}, 11'd0);
        check("rst_async_all", outs, c_RST);
        tick; check("rst_held", outs, c_RST);
        reset = 1'b0;
        tick; check("post_rst_nop", outs, c_NOP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
